id_ex_pipe: RTL and testbench

- ID/EX pipeline register. Sits directly downstream of the register file.
- Captures the decode-stage bundle (PC, register indices, immediate, control word) and the register-file read data RD1/RD2, then presents it to EX.
- Detects load-use hazards against the instruction in EX and inserts bubbles. Honours EX back-pressure and branch flush.
- Counts inserted bubbles for performance analysis.

---
 rtl/riscv_pipe_pkg.sv | 26 ++
 rtl/id_ex_pipe_load_use_detect.sv | 31 +++
 rtl/id_ex_pipe.sv | 131 +++++++++++++
 tb/tb_id_ex_pipe.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pipe_pkg.sv
// riscv_pipe_pkg: definitions shared by the pipeline register slice.
//   - Default datapath and control-word widths.
//   - Bit positions inside the decoded control word.
//   - Architectural zero-register index.
package riscv_pipe_pkg;

  localparam int XLEN_DEFAULT   = 32;
  localparam int CTRL_W_DEFAULT = 16;

  // Control-word bit indices
  localparam int CTRL_MEM_READ      = 0;
  localparam int CTRL_MEM_WRITE     = 1;
  localparam int CTRL_REG_WRITE     = 2;
  localparam int CTRL_BRANCH        = 3;
  localparam int CTRL_JUMP          = 4;
  localparam int CTRL_ALU_SRC       = 5;
  localparam int CTRL_RESULT_SRC_LO = 6;
  localparam int CTRL_RESULT_SRC_HI = 7;
  localparam int CTRL_ALU_OP_LO     = 8;
  localparam int CTRL_ALU_OP_HI     = 10;

  typedef logic [4:0] reg_idx_t;

  localparam reg_idx_t REG_ZERO = 5'd0;

endpackage

// File: rtl/id_ex_pipe_load_use_detect.sv
// load_use_detect: combinational load-use hazard comparator.
// A hazard exists when EX holds a valid load with a non-zero destination and
// the valid instruction in decode actually reads that register.
// Ports:
//   valid_e, mem_read, rd_e  : state of the instruction in EX
//   valid_d, use_rs1, rs1,
//   use_rs2, rs2             : source usage of the instruction in decode
//   load_use                 : hazard flag
module load_use_detect
  import riscv_pipe_pkg::*;
(
  input  logic     valid_e,
  input  logic     mem_read,
  input  reg_idx_t rd_e,
  input  logic     valid_d,
  input  logic     use_rs1,
  input  reg_idx_t rs1,
  input  logic     use_rs2,
  input  reg_idx_t rs2,
  output logic     load_use
);

  logic hit_rs1;
  logic hit_rs2;

  assign hit_rs1  = use_rs1 && (rs1 == rd_e);
  assign hit_rs2  = use_rs2 && (rs2 == rd_e);
  assign load_use = valid_e && mem_read && (rd_e != REG_ZERO) && valid_d
                    && (hit_rs1 || hit_rs2);

endmodule

// File: rtl/id_ex_pipe.sv
// id_ex_pipe: ID/EX pipeline register with load-use bubble insertion.
// Captures the decode bundle plus register-file read data and presents it to
// EX one cycle later. Honours EX back-pressure (ready_e) and branch flush
// (flush_e), and counts inserted load-use bubbles (saturating).
// Ports:
//   clk, rst_n                       : clock, asynchronous active-low reset
//   valid_d, pc_d, rs1_d, rs2_d, rd_d,
//   use_rs1_d, use_rs2_d, imm_d, ctrl_d,
//   rd1_d, rd2_d                     : decode bundle and operands
//   ready_e, flush_e                 : EX back-pressure / redirect
//   wb_we, wb_rd, wb_data            : writeback port (used only for bypass)
//   valid_e, pc_e, rs1_e, rs2_e, rd_e,
//   imm_e, ctrl_e, rd1_e, rd2_e      : registered bundle to EX
//   stall_d                          : freeze PC and IF/ID (combinational)
//   bubble_cnt                       : saturating load-use bubble count
// Build option: define WB_BYPASS_EN to forward same-edge writeback data into
// rd1_e/rd2_e on capture; otherwise the wb_* inputs are ignored.
module id_ex_pipe
  import riscv_pipe_pkg::*;
#(
  parameter int XLEN   = XLEN_DEFAULT,
  parameter int CTRL_W = CTRL_W_DEFAULT,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_d,
  input  logic [XLEN-1:0]   pc_d,
  input  logic [4:0]        rs1_d,
  input  logic [4:0]        rs2_d,
  input  logic [4:0]        rd_d,
  input  logic              use_rs1_d,
  input  logic              use_rs2_d,
  input  logic [XLEN-1:0]   imm_d,
  input  logic [CTRL_W-1:0] ctrl_d,
  input  logic [XLEN-1:0]   rd1_d,
  input  logic [XLEN-1:0]   rd2_d,
  input  logic              ready_e,
  input  logic              flush_e,
  input  logic              wb_we,
  input  logic [4:0]        wb_rd,
  input  logic [XLEN-1:0]   wb_data,
  output logic              valid_e,
  output logic [XLEN-1:0]   pc_e,
  output logic [4:0]        rs1_e,
  output logic [4:0]        rs2_e,
  output logic [4:0]        rd_e,
  output logic [XLEN-1:0]   imm_e,
  output logic [CTRL_W-1:0] ctrl_e,
  output logic [XLEN-1:0]   rd1_e,
  output logic [XLEN-1:0]   rd2_e,
  output logic              stall_d,
  output logic [CNT_W-1:0]  bubble_cnt
);

  logic            load_use;
  logic [XLEN-1:0] op1;
  logic [XLEN-1:0] op2;

  load_use_detect u_load_use_detect (
    .valid_e  (valid_e),
    .mem_read (ctrl_e[CTRL_MEM_READ]),
    .rd_e     (rd_e),
    .valid_d  (valid_d),
    .use_rs1  (use_rs1_d),
    .rs1      (rs1_d),
    .use_rs2  (use_rs2_d),
    .rs2      (rs2_d),
    .load_use (load_use)
  );

  // A flush discards decode anyway, so there is nothing to freeze.
  assign stall_d = !flush_e && valid_d && (!ready_e || load_use);

`ifdef WB_BYPASS_EN
  // The register file returns the old value when it is written on the same
  // edge it is read, so pick up the writeback data directly.
  assign op1 = (wb_we && (wb_rd != REG_ZERO) && (wb_rd == rs1_d)) ? wb_data : rd1_d;
  assign op2 = (wb_we && (wb_rd != REG_ZERO) && (wb_rd == rs2_d)) ? wb_data : rd2_d;
`else
  assign op1 = rd1_d;
  assign op2 = rd2_d;
  logic unused_wb;
  assign unused_wb = ^{wb_we, wb_rd, wb_data};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_e    <= 1'b0;
      pc_e       <= '0;
      rs1_e      <= '0;
      rs2_e      <= '0;
      rd_e       <= '0;
      imm_e      <= '0;
      ctrl_e     <= '0;
      rd1_e      <= '0;
      rd2_e      <= '0;
      bubble_cnt <= '0;
    end else if (flush_e) begin
      valid_e <= 1'b0;
      pc_e    <= '0;
      rs1_e   <= '0;
      rs2_e   <= '0;
      rd_e    <= '0;
      imm_e   <= '0;
      ctrl_e  <= '0;
      rd1_e   <= '0;
      rd2_e   <= '0;
    end else if (!ready_e) begin
      // EX is busy: hold everything, even if a hazard is pending.
    end else if (load_use) begin
      // Bubble: only the valid bit and control word are killed.
      valid_e <= 1'b0;
      ctrl_e  <= '0;
      if (bubble_cnt != {CNT_W{1'b1}}) begin
        bubble_cnt <= bubble_cnt + CNT_W'(1);
      end
    end else begin
      valid_e <= valid_d;
      pc_e    <= pc_d;
      rs1_e   <= rs1_d;
      rs2_e   <= rs2_d;
      rd_e    <= rd_d;
      imm_e   <= imm_d;
      ctrl_e  <= ctrl_d;
      rd1_e   <= op1;
      rd2_e   <= op2;
    end
  end

endmodule

// File: tb/tb_id_ex_pipe.sv
// tb_id_ex_pipe: directed self-checking bench for id_ex_pipe.
// The bubble counter is instantiated 3 bits wide so saturation is reachable.
module tb_id_ex_pipe;

  localparam int XLEN   = 32;
  localparam int CTRL_W = 16;
  localparam int CNT_W  = 3;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              valid_d;
  logic [XLEN-1:0]   pc_d;
  logic [4:0]        rs1_d, rs2_d, rd_d;
  logic              use_rs1_d, use_rs2_d;
  logic [XLEN-1:0]   imm_d;
  logic [CTRL_W-1:0] ctrl_d;
  logic [XLEN-1:0]   rd1_d, rd2_d;
  logic              ready_e, flush_e;
  logic              wb_we;
  logic [4:0]        wb_rd;
  logic [XLEN-1:0]   wb_data;
  logic              valid_e;
  logic [XLEN-1:0]   pc_e;
  logic [4:0]        rs1_e, rs2_e, rd_e;
  logic [XLEN-1:0]   imm_e;
  logic [CTRL_W-1:0] ctrl_e;
  logic [XLEN-1:0]   rd1_e, rd2_e;
  logic              stall_d;
  logic [CNT_W-1:0]  bubble_cnt;

  int checks = 0;
  int errors = 0;
  int exp_bub;
  logic [XLEN-1:0] exp_rd2;

  id_ex_pipe #(.XLEN(XLEN), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .valid_d(valid_d), .pc_d(pc_d),
    .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d),
    .use_rs1_d(use_rs1_d), .use_rs2_d(use_rs2_d), .imm_d(imm_d),
    .ctrl_d(ctrl_d), .rd1_d(rd1_d), .rd2_d(rd2_d),
    .ready_e(ready_e), .flush_e(flush_e),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .valid_e(valid_e), .pc_e(pc_e), .rs1_e(rs1_e), .rs2_e(rs2_e),
    .rd_e(rd_e), .imm_e(imm_e), .ctrl_e(ctrl_e), .rd1_e(rd1_e),
    .rd2_e(rd2_e), .stall_d(stall_d), .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one decode-slot instruction; immediate is derived from the PC.
  task automatic drive(input logic v, input logic [31:0] pc, input logic [4:0] r1,
                       input logic [4:0] r2, input logic [4:0] rd, input logic u1,
                       input logic u2, input logic [15:0] ctrl,
                       input logic [31:0] d1, input logic [31:0] d2);
    valid_d = v; pc_d = pc; rs1_d = r1; rs2_d = r2; rd_d = rd;
    use_rs1_d = u1; use_rs2_d = u2; ctrl_d = ctrl;
    imm_d = pc + 32'h1000; rd1_d = d1; rd2_d = d2;
  endtask

  initial begin
    rst_n = 1'b1; ready_e = 1'b1; flush_e = 1'b0;
    wb_we = 1'b0; wb_rd = '0; wb_data = '0;
    drive(1'b0, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 16'h0, 32'h0, 32'h0);

    // Asynchronous reset between edges
    #3 rst_n = 1'b0;
    #1;
    check("rst_valid_e", 64'(valid_e), 64'd0);
    check("rst_pc_e", 64'(pc_e), 64'd0);
    check("rst_ctrl_e", 64'(ctrl_e), 64'd0);
    check("rst_bubble", 64'(bubble_cnt), 64'd0);
    tick(); tick();
    rst_n = 1'b1;

    // Streaming ALU instructions
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'(4 * i), 5'd1, 5'd2, 5'(10 + i), 1'b1, 1'b1, 16'h0004,
            32'(256 + i), 32'h0);
      #1 check($sformatf("stream%0d_stall", i), 64'(stall_d), 64'd0);
      tick();
      check($sformatf("stream%0d_valid", i), 64'(valid_e), 64'd1);
      check($sformatf("stream%0d_pc", i), 64'(pc_e), 64'(4 * i));
      check($sformatf("stream%0d_rd", i), 64'(rd_e), 64'(10 + i));
      check($sformatf("stream%0d_rd1", i), 64'(rd1_e), 64'(256 + i));
    end
    check("stream_imm", 64'(imm_e), 64'h100C);

    // Load-use: lw x5 then add x6, x5, ...
    drive(1'b1, 32'h10, 5'd1, 5'd0, 5'd5, 1'b1, 1'b0, 16'h0005, 32'h0, 32'h0);
    tick();
    check("lw_ctrl_e", 64'(ctrl_e), 64'h5);
    drive(1'b1, 32'h14, 5'd5, 5'd2, 5'd6, 1'b1, 1'b1, 16'h0004, 32'h55, 32'h0);
    #1 check("lu_stall", 64'(stall_d), 64'd1);
    tick();
    check("lu_valid_e", 64'(valid_e), 64'd0);
    check("lu_ctrl_e", 64'(ctrl_e), 64'd0);
    check("lu_pc_kept", 64'(pc_e), 64'h10);
    check("lu_bubble", 64'(bubble_cnt), 64'd1);
    check("lu_stall_clr", 64'(stall_d), 64'd0);
    tick();
    check("lu_add_valid", 64'(valid_e), 64'd1);
    check("lu_add_pc", 64'(pc_e), 64'h14);
    check("lu_add_rd1", 64'(rd1_e), 64'h55);

    // Masking: rd_e = x0
    drive(1'b1, 32'h20, 5'd1, 5'd0, 5'd0, 1'b1, 1'b0, 16'h0001, 32'h0, 32'h0);
    tick();
    drive(1'b1, 32'h24, 5'd0, 5'd0, 5'd6, 1'b1, 1'b1, 16'h0004, 32'h0, 32'h0);
    #1 check("x0_stall", 64'(stall_d), 64'd0);
    tick();
    check("x0_pc", 64'(pc_e), 64'h24);
    check("x0_bubble", 64'(bubble_cnt), 64'd1);

    // Masking: rs2 matches but is not used
    drive(1'b1, 32'h28, 5'd1, 5'd0, 5'd5, 1'b1, 1'b0, 16'h0005, 32'h0, 32'h0);
    tick();
    drive(1'b1, 32'h2C, 5'd1, 5'd5, 5'd6, 1'b1, 1'b0, 16'h0004, 32'h0, 32'h0);
    #1 check("nouse2_stall", 64'(stall_d), 64'd0);
    tick();
    check("nouse2_valid", 64'(valid_e), 64'd1);
    check("nouse2_bubble", 64'(bubble_cnt), 64'd1);

    // Masking: invalid decode slot
    drive(1'b1, 32'h30, 5'd1, 5'd0, 5'd5, 1'b1, 1'b0, 16'h0005, 32'h0, 32'h0);
    tick();
    drive(1'b0, 32'h34, 5'd5, 5'd5, 5'd6, 1'b1, 1'b1, 16'h0004, 32'h0, 32'h0);
    #1 check("inv_stall", 64'(stall_d), 64'd0);
    tick();
    check("inv_valid", 64'(valid_e), 64'd0);
    check("inv_bubble", 64'(bubble_cnt), 64'd1);

    // Back-pressure with a pending hazard
    drive(1'b1, 32'h40, 5'd1, 5'd0, 5'd5, 1'b1, 1'b0, 16'h0005, 32'h0, 32'h0);
    tick();
    drive(1'b1, 32'h44, 5'd5, 5'd2, 5'd6, 1'b1, 1'b1, 16'h0004, 32'h0, 32'h0);
    ready_e = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1 check($sformatf("bp%0d_stall", i), 64'(stall_d), 64'd1);
      tick();
      check($sformatf("bp%0d_pc", i), 64'(pc_e), 64'h40);
      check($sformatf("bp%0d_valid", i), 64'(valid_e), 64'd1);
      check($sformatf("bp%0d_ctrl", i), 64'(ctrl_e), 64'h5);
      check($sformatf("bp%0d_bubble", i), 64'(bubble_cnt), 64'd1);
    end

    // Flush together with load_use
    ready_e = 1'b1; flush_e = 1'b1;
    #1 check("fl_stall", 64'(stall_d), 64'd0);
    tick();
    check("fl_valid", 64'(valid_e), 64'd0);
    check("fl_ctrl", 64'(ctrl_e), 64'd0);
    check("fl_bubble", 64'(bubble_cnt), 64'd1);
    flush_e = 1'b0;

    // Counter saturation at 3'b111
    exp_bub = 1;
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, 32'h50, 5'd1, 5'd0, 5'd5, 1'b1, 1'b0, 16'h0005, 32'h0, 32'h0);
      tick();
      drive(1'b1, 32'h54, 5'd2, 5'd5, 5'd6, 1'b0, 1'b1, 16'h0004, 32'h0, 32'h0);
      #1 check($sformatf("sat%0d_stall", i), 64'(stall_d), 64'd1);
      tick();
      exp_bub = (exp_bub < 7) ? exp_bub + 1 : 7;
      check($sformatf("sat%0d_bubble", i), 64'(bubble_cnt), 64'(exp_bub));
    end

    // Writeback bypass on capture
    drive(1'b1, 32'h60, 5'd3, 5'd7, 5'd8, 1'b1, 1'b1, 16'h0004, 32'h11, 32'h0);
    wb_we = 1'b1; wb_rd = 5'd7; wb_data = 32'hDEADBEEF;
`ifdef WB_BYPASS_EN
    exp_rd2 = 32'hDEADBEEF;
`else
    exp_rd2 = 32'h0;
`endif
    tick();
    check("byp_rd2", 64'(rd2_e), 64'(exp_rd2));
    check("byp_rd1", 64'(rd1_e), 64'h11);
    drive(1'b1, 32'h64, 5'd3, 5'd0, 5'd8, 1'b1, 1'b1, 16'h0004, 32'h11, 32'h22);
    wb_rd = 5'd0;
    tick();
    check("byp_x0_rd2", 64'(rd2_e), 64'h22);
    wb_we = 1'b0;

    // Reset mid-operation takes effect without a clock edge
    check("pre_rst_valid", 64'(valid_e), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 64'(valid_e), 64'd0);
    check("mid_rst_pc", 64'(pc_e), 64'd0);
    check("mid_rst_rd2", 64'(rd2_e), 64'd0);
    check("mid_rst_bubble", 64'(bubble_cnt), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
